dcache_controller: RTL and testbench



---
 rtl/dcache_controller.sv | 175 +++++++++++++++++
 tb/tb_dcache_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Geometry: 32 lines x 32 bytes; address = tag[31:10], index[9:5], word[4:2].
// Tag word format: {valid, dirty, tag[21:0]}. Tag and data SRAMs read
// combinationally and write on the rising edge; memory completes a line
// transfer with a single-cycle mem_ack_i pulse, carrying refill data on
// mem_data_i in that same cycle.
module dcache_controller (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  p1_addr_i,
   input  logic [31:0]  p1_data_i,
   input  logic         p1_MemRead_i,
   input  logic         p1_MemWrite_i,
   output logic [31:0]  p1_data_o,
   output logic         p1_stall_o,
   output logic [4:0]   tag_addr_o,
   output logic [23:0]  tag_data_o,
   output logic         tag_enable_o,
   output logic         tag_write_o,
   input  logic [23:0]  tag_data_i,
   output logic [4:0]   data_addr_o,
   output logic [255:0] data_wdata_o,
   output logic         data_enable_o,
   output logic         data_write_o,
   input  logic [255:0] data_rdata_i,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   input  logic         mem_ack_i,
   input  logic [255:0] mem_data_i
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_MISS,
      S_WRITEBACK,
      S_READMISS,
      S_READMISSOK
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;

   logic        req;
   logic        hit;
   logic [21:0] req_tag;
   logic [4:0]  req_index;
   logic [7:0]  word_lsb;
   logic [255:0] merged_line;
   logic        unused_byte_offset;

   assign req       = p1_MemRead_i | p1_MemWrite_i;
   assign req_tag   = p1_addr_i[31:10];
   assign req_index = p1_addr_i[9:5];
   assign word_lsb  = {p1_addr_i[4:2], 5'b00000};
   assign hit       = tag_data_i[23] & (tag_data_i[21:0] == req_tag);

   // Byte offset is irrelevant: the cache only handles whole 32-bit words.
   assign unused_byte_offset = ^p1_addr_i[1:0];

   // Store-hit line: current line contents with the addressed word replaced.
   always_comb begin
      merged_line = data_rdata_i;
      merged_line[word_lsb +: 32] = p1_data_i;
   end

   // State and init-sweep counter registers; reset restarts the tag sweep.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_INIT;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state and output decode; all memory-side outputs are pure
   // functions of state so reset removes an outstanding request at once.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      p1_stall_o    = 1'b1;
      p1_data_o     = data_rdata_i[word_lsb +: 32];
      tag_addr_o    = req_index;
      tag_data_o    = '0;
      tag_enable_o  = 1'b0;
      tag_write_o   = 1'b0;
      data_addr_o   = req_index;
      data_wdata_o  = '0;
      data_enable_o = 1'b0;
      data_write_o  = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;

      unique case (state_q)
         S_INIT: begin
            tag_enable_o = 1'b1;
            tag_write_o  = 1'b1;
            tag_addr_o   = count_q;
            count_d      = count_q + 5'd1;
            if (count_q == 5'd31) begin
               state_d = S_IDLE;
            end
         end

         S_IDLE: begin
            p1_stall_o = 1'b0;
            if (req) begin
               tag_enable_o  = 1'b1;
               data_enable_o = 1'b1;
               if (hit) begin
                  if (p1_MemWrite_i) begin
                     data_write_o = 1'b1;
                     data_wdata_o = merged_line;
                     tag_write_o  = 1'b1;
                     tag_data_o   = {2'b11, req_tag};
                  end
               end else begin
                  p1_stall_o = 1'b1;
                  state_d    = S_MISS;
               end
            end
         end

         S_MISS: begin
            tag_enable_o = 1'b1;
            if (tag_data_i[23] & tag_data_i[22]) begin
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_READMISS;
            end
         end

         S_WRITEBACK: begin
            tag_enable_o  = 1'b1;
            data_enable_o = 1'b1;
            mem_enable_o  = 1'b1;
            mem_write_o   = 1'b1;
            mem_addr_o    = {tag_data_i[21:0], req_index, 5'b00000};
            mem_data_o    = data_rdata_i;
            if (mem_ack_i) begin
               state_d = S_READMISS;
            end
         end

         S_READMISS: begin
            tag_enable_o  = 1'b1;
            data_enable_o = 1'b1;
            mem_enable_o  = 1'b1;
            mem_addr_o    = {p1_addr_i[31:5], 5'b00000};
            if (mem_ack_i) begin
               data_write_o = 1'b1;
               data_wdata_o = mem_data_i;
               tag_write_o  = 1'b1;
               tag_data_o   = {2'b10, req_tag};
               state_d      = S_READMISSOK;
            end
         end

         S_READMISSOK: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller: SRAM and memory models plus an
// architectural memory image and a line-level cache directory model.
`timescale 1ns/1ps
module tb_dcache_controller;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [31:0]  p1_addr_i = '0;
   logic [31:0]  p1_data_i = '0;
   logic         p1_MemRead_i = 1'b0;
   logic         p1_MemWrite_i = 1'b0;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic [4:0]   tag_addr_o;
   logic [23:0]  tag_data_o;
   logic         tag_enable_o, tag_write_o;
   logic [23:0]  tag_data_i;
   logic [4:0]   data_addr_o;
   logic [255:0] data_wdata_o;
   logic         data_enable_o, data_write_o;
   logic [255:0] data_rdata_i;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_enable_o, mem_write_o;
   logic         mem_ack_i;
   logic [255:0] mem_data_i;

   logic         resp_ack;
   logic         stray_ack = 1'b0;
   int           mem_lat = 4;
   logic [31:0]  last_wb_addr;
   logic [31:0]  last_rd_addr;

   int vectors = 0;
   int miscompares = 0;

   // SRAM arrays and a preload flag that fills them with junk during reset
   logic [23:0]  tag_mem  [32];
   logic [255:0] data_mem [32];
   logic         preload = 1'b1;

   // Cache directory model and memory images (off-chip and architectural)
   logic         mvalid [32];
   logic         mdirty [32];
   logic [21:0]  mtag   [32];
   logic [255:0] mem_img  [int unsigned];
   logic [255:0] arch_img [int unsigned];

   dcache_controller dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
      .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .tag_addr_o(tag_addr_o), .tag_data_o(tag_data_o),
      .tag_enable_o(tag_enable_o), .tag_write_o(tag_write_o),
      .tag_data_i(tag_data_i),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_enable_o(data_enable_o), .data_write_o(data_write_o),
      .data_rdata_i(data_rdata_i),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   assign tag_data_i   = tag_mem[tag_addr_o];
   assign data_rdata_i = data_mem[data_addr_o];
   assign mem_ack_i    = resp_ack | stray_ack;

   // SRAM write ports (or junk fill while preload is set)
   always @(posedge clk_i) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) begin
            tag_mem[i]  <= 24'hFFFFFF ^ 24'(i);
            data_mem[i] <= {8{32'hEEEE0000 | 32'(i)}};
         end
      end else begin
         if (tag_enable_o && tag_write_o) tag_mem[tag_addr_o] <= tag_data_o;
         if (data_enable_o && data_write_o) data_mem[data_addr_o] <= data_wdata_o;
      end
   end

   function automatic logic [255:0] defaultLine(input int unsigned ln);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'(ln * 8 + w) ^ 32'h5A5A0000;
      return l;
   endfunction

   function automatic logic [255:0] memLine(input int unsigned ln);
      if (mem_img.exists(ln)) return mem_img[ln];
      return defaultLine(ln);
   endfunction

   function automatic logic [255:0] archLine(input int unsigned ln);
      if (arch_img.exists(ln)) return arch_img[ln];
      return defaultLine(ln);
   endfunction

   function automatic logic [31:0] archWord(input logic [31:0] addr);
      logic [255:0] l;
      l = archLine(int'(addr >> 5));
      return l[addr[4:2]*32 +: 32];
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory responder: acks the lat-th cycle of each request, checks write-backs
   initial begin
      int cnt;
      int unsigned ln;
      int unsigned vln;
      logic [4:0] idx;
      logic [255:0] l;
      l = defaultLine(32'h20);
      l[63:32] = 32'hDEADBEEF;
      mem_img[32'h20] = l;
      resp_ack = 1'b0;
      mem_data_i = '0;
      last_wb_addr = '0;
      last_rd_addr = '0;
      cnt = 0;
      forever begin
         @(posedge clk_i);
         #2;
         if (rst_i) begin
            cnt = 0;
            resp_ack = 1'b0;
         end else begin
            if (resp_ack) begin
               resp_ack = 1'b0;
               cnt = 0;
            end
            if (mem_enable_o) begin
               cnt++;
               if (cnt == mem_lat) begin
                  resp_ack = 1'b1;
                  if (mem_write_o) begin
                     idx = p1_addr_i[9:5];
                     vln = int'({mtag[idx], idx});
                     checkOutput("writeback addr", 256'(mem_addr_o), 256'({mtag[idx], idx, 5'b00000}));
                     checkOutput("writeback line", mem_data_o, archLine(vln));
                     mem_img[int'(mem_addr_o >> 5)] = mem_data_o;
                     last_wb_addr = mem_addr_o;
                  end else begin
                     ln = int'(mem_addr_o >> 5);
                     mem_data_i = memLine(ln);
                     last_rd_addr = mem_addr_o;
                  end
               end
            end else begin
               cnt = 0;
            end
         end
      end
   end

   // Per-cycle compare: load data against the architectural image, and a
   // quiet SRAM/memory interface whenever the controller idles without a request
   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_i && !p1_stall_o) begin
            if (p1_MemRead_i && !p1_MemWrite_i)
               checkOutput("load data", 256'(p1_data_o), 256'(archWord(p1_addr_i)));
            else if (!p1_MemRead_i && !p1_MemWrite_i)
               checkOutput("idle quiet", 256'({tag_enable_o, tag_write_o, data_enable_o, data_write_o, mem_enable_o}), 256'(0));
         end
      end
   end

   task automatic holdAndRelease();
      repeat (3) @(posedge clk_i);
      #1;
      preload = 1'b0;
      rst_i = 1'b0;
   endtask

   task automatic initCheck(input int strayAt);
      int cnt;
      int nz;
      bit ok;
      cnt = 0;
      ok = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_i);
         if (!p1_stall_o) break;
         if (!(tag_enable_o && tag_write_o && tag_addr_o == cnt[4:0] && tag_data_o == 24'h0)) ok = 1'b0;
         stray_ack = (cnt == strayAt);
         cnt++;
      end
      stray_ack = 1'b0;
      checkOutput("init stall cycles", 256'(cnt), 256'(32));
      checkOutput("init sweep pattern", 256'(ok), 256'(1));
      nz = 0;
      for (int i = 0; i < 32; i++) if (tag_mem[i] !== 24'h0) nz++;
      checkOutput("tags cleared", 256'(nz), 256'(0));
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input bit rd, input bit wr, input int lat,
                                output int stalls, output logic [31:0] rdata);
      logic [4:0]   idx;
      logic [21:0]  tg;
      bit           hitm, done;
      int           expStall;
      int unsigned  ln;
      logic [255:0] l;
      idx = addr[9:5];
      tg = addr[31:10];
      ln = int'(addr >> 5);
      hitm = mvalid[idx] && (mtag[idx] == tg);
      expStall = hitm ? 0 : (3 + lat + ((mvalid[idx] && mdirty[idx]) ? lat : 0));
      mem_lat = lat;
      p1_addr_i = addr;
      p1_data_i = data;
      p1_MemRead_i = rd;
      p1_MemWrite_i = wr;
      stalls = 0;
      done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         if (!p1_stall_o) begin
            done = 1'b1;
            break;
         end
         stalls++;
      end
      rdata = p1_data_o;
      checkOutput("request completes", 256'(done), 256'(1));
      checkOutput("stall cycles", 256'(stalls), 256'(expStall));
      mvalid[idx] = 1'b1;
      mtag[idx] = tg;
      if (!hitm) mdirty[idx] = 1'b0;
      if (wr) begin
         l = archLine(ln);
         l[addr[4:2]*32 +: 32] = data;
         arch_img[ln] = l;
         mdirty[idx] = 1'b1;
      end
      @(posedge clk_i);
      #1;
      p1_MemRead_i = 1'b0;
      p1_MemWrite_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      int st;
      logic [31:0] rd;
      logic [255:0] l;
      bit ok;
      for (int i = 0; i < 32; i++) begin
         mvalid[i] = 1'b0;
         mdirty[i] = 1'b0;
         mtag[i] = '0;
      end
      l = defaultLine(32'h20);
      l[63:32] = 32'hDEADBEEF;
      arch_img[32'h20] = l;

      // Reset values
      rst_i = 1'b1;
      @(negedge clk_i);
      checkOutput("reset stall", 256'(p1_stall_o), 256'(1));
      checkOutput("reset mem_enable/write", 256'({mem_enable_o, mem_write_o}), 256'(0));
      checkOutput("reset mem_addr", 256'(mem_addr_o), 256'(0));
      checkOutput("reset mem_data", mem_data_o, 256'(0));
      checkOutput("reset tag port", 256'({tag_enable_o, tag_write_o, tag_addr_o, tag_data_o}), 256'({2'b11, 5'd0, 24'h0}));
      holdAndRelease();
      initCheck(-1);

      // Cold load miss, refill with DEADBEEF in word 1
      applyStimulus(32'h0000_0404, 32'h0, 1'b1, 1'b0, 4, st, rd);
      checkOutput("cold load stalls", 256'(st), 256'(7));
      checkOutput("cold load data", 256'(rd), 256'(32'hDEADBEEF));
      checkOutput("cold load mem addr", 256'(last_rd_addr), 256'(32'h0000_0400));
      checkOutput("cold load tag", 256'(tag_mem[0]), 256'(24'h800001));

      // Store hit
      applyStimulus(32'h0000_0408, 32'h1234_5678, 1'b0, 1'b1, 4, st, rd);
      checkOutput("store hit stalls", 256'(st), 256'(0));
      checkOutput("store hit data word", 256'(data_mem[0][95:64]), 256'(32'h1234_5678));
      checkOutput("store hit tag dirty", 256'(tag_mem[0]), 256'(24'hC00001));

      // Dirty conflict miss on index 0
      applyStimulus(32'h0000_0C00, 32'h0, 1'b1, 1'b0, 3, st, rd);
      checkOutput("dirty miss stalls", 256'(st), 256'(9));
      checkOutput("dirty miss wb addr", 256'(last_wb_addr), 256'(32'h0000_0400));
      l = mem_img[32'h20];
      checkOutput("dirty miss wb word2", 256'(l[95:64]), 256'(32'h1234_5678));
      checkOutput("dirty miss rd addr", 256'(last_rd_addr), 256'(32'h0000_0C00));
      checkOutput("dirty miss data", 256'(rd), 256'(32'h5A5A0300));
      checkOutput("dirty miss tag", 256'(tag_mem[0]), 256'(24'h800003));

      applyStimulus(32'h0000_0C04, 32'h0, 1'b1, 1'b0, 3, st, rd);
      checkOutput("hit other word stalls", 256'(st), 256'(0));

      // Store miss to clean (invalid) line
      applyStimulus(32'h0000_2040, 32'hCAFE_F00D, 1'b0, 1'b1, 2, st, rd);
      checkOutput("store miss stalls", 256'(st), 256'(5));
      checkOutput("store miss tag", 256'(tag_mem[2]), 256'(24'hC00008));
      checkOutput("store miss data", 256'(data_mem[2][31:0]), 256'(32'hCAFE_F00D));
      applyStimulus(32'h0000_2040, 32'h0, 1'b1, 1'b0, 2, st, rd);
      checkOutput("reload stored word", 256'(rd), 256'(32'hCAFE_F00D));

      // Read and write together behave as a store
      applyStimulus(32'h0000_2044, 32'h0BAD_F00D, 1'b1, 1'b1, 2, st, rd);
      applyStimulus(32'h0000_2044, 32'h0, 1'b1, 1'b0, 2, st, rd);
      checkOutput("rd+wr acts as store", 256'(rd), 256'(32'h0BAD_F00D));

      // Reset in the middle of a refill
      mem_lat = 20;
      p1_addr_i = 32'h0000_3060;
      p1_MemRead_i = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_i);
         if (mem_enable_o && !mem_write_o) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("readmiss reached", 256'(ok), 256'(1));
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput("reset drops mem_enable", 256'(mem_enable_o), 256'(0));
      checkOutput("reset raises stall", 256'(p1_stall_o), 256'(1));
      p1_MemRead_i = 1'b0;
      for (int i = 0; i < 32; i++) begin
         mvalid[i] = 1'b0;
         mdirty[i] = 1'b0;
      end
      arch_img = mem_img;
      holdAndRelease();
      initCheck(5);

      // Stray ack in IDLE with no request
      stray_ack = 1'b1;
      @(posedge clk_i);
      #1;
      stray_ack = 1'b0;
      @(negedge clk_i);
      checkOutput("idle after stray ack", 256'({p1_stall_o, tag_write_o}), 256'(0));
      @(posedge clk_i);
      #1;

      applyStimulus(32'h0000_3060, 32'h0, 1'b1, 1'b0, 3, st, rd);
      applyStimulus(32'h0000_0408, 32'h0, 1'b1, 1'b0, 3, st, rd);
      checkOutput("post-reset miss stalls", 256'(st), 256'(6));
      checkOutput("written-back word persists", 256'(rd), 256'(32'h1234_5678));
      applyStimulus(32'h0000_2040, 32'h0, 1'b1, 1'b0, 3, st, rd);
      checkOutput("dirty line lost on reset", 256'(rd), 256'(32'h5A5A0810));

      repeat (2) @(posedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
